sdram_port_arbiter: RTL and testbench

- Shares the single-port SDRAM controller between NUM_PORTS requesters: CPU, VDP/video fetch, cartridge/GROM loader.
- Converts each requester's level req/ack handshake into the controller's rising-edge-triggered rd/we pulses.
- Tracks the controller's ready turnaround and returns read data with a one-cycle ack.
- Sits between the system bus muxes and the sdram controller. Round-robin arbitration by default.

---
 rtl/sdram_port_arbiter.sv | 178 +++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// Shares one edge-triggered SDRAM controller port among NUM_PORTS level req/ack requesters.
// Define SDRAM_ARB_PORT0_PRIO_EN to give port 0 absolute priority; otherwise pure round-robin.
module sdram_port_arbiter #(
  parameter int NUM_PORTS      = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_PORTS-1:0]    req,
  input  logic [NUM_PORTS-1:0]    req_we,
  input  logic [NUM_PORTS*25-1:0] req_addr,
  input  logic [NUM_PORTS*16-1:0] req_wdata,
  input  logic [NUM_PORTS*2-1:0]  req_wtbt,
  output logic [NUM_PORTS-1:0]    ack,
  output logic                    err,
  output logic [15:0]             rdata,
  output logic [NUM_PORTS-1:0]    grant,
  output logic [24:0]             mem_addr,
  output logic [15:0]             mem_din,
  output logic [1:0]              mem_wtbt,
  output logic                    mem_rd,
  output logic                    mem_we,
  input  logic [15:0]             mem_dout,
  input  logic                    mem_ready
);

  localparam int              PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int              CW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PW:0]     NP_W      = (PW+1)'(NUM_PORTS);
  localparam logic [CW-1:0]   TO_W      = CW'(TIMEOUT_CYCLES);
  localparam logic [PW-1:0]   LAST_PORT = PW'(NUM_PORTS - 1);

  typedef enum logic [1:0] {S_IDLE, S_GUARD, S_WAIT, S_RELEASE} state_t;

  state_t                 state_reg, state_next;
  logic [PW-1:0]          rr_ptr_reg, rr_ptr_next;
  logic [CW-1:0]          count_reg, count_next;
  logic [NUM_PORTS-1:0]   grant_reg, grant_next;
  logic [NUM_PORTS-1:0]   ack_reg, ack_next;
  logic                   err_reg, err_next;
  logic [15:0]            rdata_reg, rdata_next;
  logic [24:0]            mem_addr_reg, mem_addr_next;
  logic [15:0]            mem_din_reg, mem_din_next;
  logic [1:0]             mem_wtbt_reg, mem_wtbt_next;
  logic                   mem_rd_reg, mem_rd_next;
  logic                   mem_we_reg, mem_we_next;

  logic [24:0] port_addr  [NUM_PORTS];
  logic [15:0] port_wdata [NUM_PORTS];
  logic [1:0]  port_wtbt  [NUM_PORTS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign port_addr[gi]  = req_addr[25*gi +: 25];
      assign port_wdata[gi] = req_wdata[16*gi +: 16];
      assign port_wtbt[gi]  = req_wtbt[2*gi +: 2];
    end
  endgenerate

  // Scan from the farthest candidate down so the nearest requester after rr_ptr wins last.
  logic [PW-1:0] pick_idx;
  logic          pick_valid;
  logic          pick_rr;
  logic [PW:0]   scan_sum;

  always_comb begin
    pick_idx   = rr_ptr_reg;
    pick_valid = 1'b0;
    pick_rr    = 1'b1;
    scan_sum   = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      scan_sum = {1'b0, rr_ptr_reg} + (PW+1)'(k);
      if (scan_sum >= NP_W) scan_sum = scan_sum - NP_W;
      if (req[scan_sum[PW-1:0]]) begin
        pick_idx   = scan_sum[PW-1:0];
        pick_valid = 1'b1;
      end
    end
`ifdef SDRAM_ARB_PORT0_PRIO_EN
    if (req[0]) begin
      pick_idx   = '0;
      pick_valid = 1'b1;
      pick_rr    = 1'b0;
    end
`endif
  end

  always_comb begin
    state_next    = state_reg;
    rr_ptr_next   = rr_ptr_reg;
    count_next    = count_reg;
    grant_next    = grant_reg;
    ack_next      = '0;
    err_next      = 1'b0;
    rdata_next    = rdata_reg;
    mem_addr_next = mem_addr_reg;
    mem_din_next  = mem_din_reg;
    mem_wtbt_next = mem_wtbt_reg;
    mem_rd_next   = mem_rd_reg;
    mem_we_next   = mem_we_reg;
    case (state_reg)
      S_IDLE: begin
        if (mem_ready && pick_valid) begin
          grant_next           = '0;
          grant_next[pick_idx] = 1'b1;
          mem_addr_next        = port_addr[pick_idx];
          mem_din_next         = port_wdata[pick_idx];
          mem_wtbt_next        = port_wtbt[pick_idx];
          mem_we_next          = req_we[pick_idx];
          mem_rd_next          = ~req_we[pick_idx];
          if (pick_rr) rr_ptr_next = pick_idx;
          state_next           = S_GUARD;
        end
      end
      // Controller sees the rd/we edge this cycle; its ready is still stale.
      S_GUARD: state_next = S_WAIT;
      S_WAIT: begin
        count_next = count_reg + 1'b1;
        if (mem_ready || count_next == TO_W) begin
          ack_next    = grant_reg;
          err_next    = ~mem_ready;
          if (mem_ready && mem_rd_reg) rdata_next = mem_dout;
          mem_rd_next = 1'b0;
          mem_we_next = 1'b0;
          state_next  = S_RELEASE;
        end
      end
      S_RELEASE: begin
        grant_next = '0;
        count_next = '0;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= S_IDLE;
      rr_ptr_reg   <= LAST_PORT;
      count_reg    <= '0;
      grant_reg    <= '0;
      ack_reg      <= '0;
      err_reg      <= 1'b0;
      rdata_reg    <= '0;
      mem_addr_reg <= '0;
      mem_din_reg  <= '0;
      mem_wtbt_reg <= '0;
      mem_rd_reg   <= 1'b0;
      mem_we_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rr_ptr_reg   <= rr_ptr_next;
      count_reg    <= count_next;
      grant_reg    <= grant_next;
      ack_reg      <= ack_next;
      err_reg      <= err_next;
      rdata_reg    <= rdata_next;
      mem_addr_reg <= mem_addr_next;
      mem_din_reg  <= mem_din_next;
      mem_wtbt_reg <= mem_wtbt_next;
      mem_rd_reg   <= mem_rd_next;
      mem_we_reg   <= mem_we_next;
    end
  end

  assign ack      = ack_reg;
  assign err      = err_reg;
  assign rdata    = rdata_reg;
  assign grant    = grant_reg;
  assign mem_addr = mem_addr_reg;
  assign mem_din  = mem_din_reg;
  assign mem_wtbt = mem_wtbt_reg;
  assign mem_rd   = mem_rd_reg;
  assign mem_we   = mem_we_reg;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: SDRAM controller model, per-port requesters,
// and a negedge monitor holding a round-robin/latency reference model.
module tb_sdram_port_arbiter;
  localparam int NP = 3;
  localparam int TO = 255;

  logic clk = 1'b0, reset_n = 1'b0;
  logic [NP-1:0]    req = '0, req_we = '0;
  logic [NP*25-1:0] req_addr = '0;
  logic [NP*16-1:0] req_wdata = '0;
  logic [NP*2-1:0]  req_wtbt = '0;
  logic [NP-1:0]    ack, grant;
  logic             err;
  logic [15:0]      rdata, mem_din, mem_dout = '0;
  logic [24:0]      mem_addr;
  logic [1:0]       mem_wtbt;
  logic             mem_rd, mem_we, mem_ready = 1'b0;

  int checks = 0, passes = 0;

  sdram_port_arbiter #(.NUM_PORTS(NP), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wtbt(req_wtbt), .ack(ack), .err(err), .rdata(rdata),
    .grant(grant), .mem_addr(mem_addr), .mem_din(mem_din), .mem_wtbt(mem_wtbt),
    .mem_rd(mem_rd), .mem_we(mem_we), .mem_dout(mem_dout), .mem_ready(mem_ready));

  always #5 clk = ~clk;

  task automatic check(input string name, input bit ok, input string got, input string want);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %s, expected %s", name, got, want);
  endtask

  function automatic logic [15:0] dflt(input int a);
    return 16'(a) ^ 16'hA5A5;
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d, input logic [1:0] be);
    return {be[1] ? d[15:8] : old[15:8], be[0] ? d[7:0] : old[7:0]};
  endfunction

  // Controller model: reacts to rd/we rises, drops ready for lat cycles unless read hit.
  logic [15:0] ctl_mem [int];
  bit startup_hold = 1, stuck_mode = 0, hit_mode = 0, rand_mode = 0;
  int lat = 6, cnt = 0, pend_addr = 0, rise_count = 0;
  bit busy = 0, rd_pend = 0, prev_rd = 0, prev_we = 0;

  always begin
    int a;
    logic [15:0] old;
    bit hit;
    @(posedge clk); #2;
    if ((mem_rd && !prev_rd) || (mem_we && !prev_we)) begin
      rise_count++;
      a = int'(mem_addr);
      hit = hit_mode;
      if (rand_mode) begin
        lat = $urandom_range(1, 8);
        hit = ($urandom_range(0, 3) == 0);
      end
      if (mem_we) begin
        old = ctl_mem.exists(a) ? ctl_mem[a] : dflt(a);
        ctl_mem[a] = merge(old, mem_din, mem_wtbt);
      end
      if (mem_rd && hit) mem_dout = ctl_mem.exists(a) ? ctl_mem[a] : dflt(a);
      else begin
        busy = 1; cnt = lat; rd_pend = mem_rd; pend_addr = a;
      end
    end else if (busy && !stuck_mode) begin
      cnt--;
      if (cnt <= 0) begin
        busy = 0;
        if (rd_pend) mem_dout = ctl_mem.exists(pend_addr) ? ctl_mem[pend_addr] : dflt(pend_addr);
      end
    end
    prev_rd = mem_rd; prev_we = mem_we;
    mem_ready = !(startup_hold || busy);
  end

  typedef struct { int port; bit we; logic [15:0] data; bit err; } exp_t;
  exp_t exp_q[$];
  logic [15:0] ref_mem [int];

  task automatic do_req(input int p, input bit we, input int addr, input logic [15:0] wd,
                        input logic [1:0] be, input bit exp_err, output int n);
    exp_t e;
    logic [15:0] cur;
    cur = ref_mem.exists(addr) ? ref_mem[addr] : dflt(addr);
    e.port = p; e.we = we; e.err = exp_err; e.data = cur;
    if (we) ref_mem[addr] = merge(cur, wd, be);
    exp_q.push_back(e);
    @(posedge clk); #1;
    req_we[p] = we; req_addr[25*p +: 25] = 25'(addr);
    req_wdata[16*p +: 16] = wd; req_wtbt[2*p +: 2] = be; req[p] = 1'b1;
    n = 0;
    forever begin
      @(posedge clk); #1; n++;
      if (ack[p]) break;
      if (n > 8000) begin
        check("ack_wait", 1'b0, $sformatf("no ack on port %0d", p), "ack within 8000 cycles");
        break;
      end
    end
    req[p] = 1'b0;
  endtask

  // Monitor: round-robin reference, WAIT/timeout timing model and scoreboard pops.
  int rr_m = NP - 1, act_p = 0, phase = 0, wait_n = 0, grant_events = 0;
  bit active = 0, after_ack = 0, prev_ready = 0, prev_rstn = 0;
  logic [NP-1:0] prev_grant = '0, prev_req = '0;
  logic [15:0] last_rd = '0;
  int grant_log[$];

  always @(negedge clk) begin
    logic [NP-1:0] exp_ack, exp_g;
    int w, idx, p, i;
    bit prio_hit;
    exp_t e;
    if (!reset_n) begin
      check("reset_outputs", ack == 0 && grant == 0 && !mem_rd && !mem_we && !err && rdata == 0 && mem_addr == 0,
            $sformatf("ack=%b grant=%b rd=%b we=%b err=%b rdata=%h addr=%h", ack, grant, mem_rd, mem_we, err, rdata, mem_addr),
            "all zero");
      active = 0; after_ack = 0; rr_m = NP - 1; last_rd = '0;
    end else begin
      exp_ack = '0;
      if (active) begin
        if (phase == 0) phase = 1;
        else begin
          wait_n++;
          if (prev_ready || wait_n == TO) exp_ack[act_p] = 1'b1;
        end
      end
      if (exp_ack != 0 || ack != 0)
        check("ack_timing", ack == exp_ack, $sformatf("ack=%b", ack), $sformatf("ack=%b", exp_ack));
      if (ack != 0) begin
        p = 0;
        for (int k = NP - 1; k >= 0; k--) if (ack[k]) p = k;
        idx = -1;
        for (int k = 0; k < exp_q.size(); k++) if (idx < 0 && exp_q[k].port == p) idx = k;
        if (idx < 0) check("ack_unexpected", 1'b0, $sformatf("ack on port %0d", p), "no ack");
        else begin
          e = exp_q[idx];
          exp_q.delete(idx);
          if (!e.we && !e.err) last_rd = e.data;
          check("ack_data", rdata == last_rd && err == e.err,
                $sformatf("port %0d rdata=%h err=%b", p, rdata, err),
                $sformatf("rdata=%h err=%b", last_rd, e.err));
        end
      end
      if (exp_ack != 0) begin
        active = 0; after_ack = 1;
        check("grant_at_ack", grant == exp_ack && !mem_rd && !mem_we,
              $sformatf("grant=%b rd=%b we=%b", grant, mem_rd, mem_we), $sformatf("grant=%b rd=0 we=0", exp_ack));
      end else if (after_ack) begin
        after_ack = 0;
        check("grant_release", grant == 0 && !mem_rd && !mem_we,
              $sformatf("grant=%b rd=%b we=%b", grant, mem_rd, mem_we), "grant=0 rd=0 we=0");
      end
      if (prev_rstn && prev_grant == 0) begin
        exp_g = '0; w = -1; prio_hit = 0;
        if (prev_ready && prev_req != 0) begin
`ifdef SDRAM_ARB_PORT0_PRIO_EN
          if (prev_req[0]) begin w = 0; prio_hit = 1; end
`endif
          for (int k = 1; k <= NP; k++) begin
            i = (rr_m + k) % NP;
            if (w < 0 && prev_req[i]) w = i;
          end
          exp_g[w] = 1'b1;
        end
        if (exp_g != 0 || grant != 0)
          check("grant_pick", grant == exp_g, $sformatf("grant=%b", grant), $sformatf("grant=%b", exp_g));
        if (grant != 0) grant_events++;
        if (exp_g != 0) begin
          if (!prio_hit) rr_m = w;
          grant_log.push_back(w);
          active = 1; act_p = w; phase = 0; wait_n = 0;
          check("grant_qualifiers",
                mem_addr == req_addr[25*w +: 25] && mem_din == req_wdata[16*w +: 16] &&
                mem_wtbt == req_wtbt[2*w +: 2] && mem_we == req_we[w] && mem_rd == !req_we[w],
                $sformatf("addr=%h din=%h wtbt=%b rd=%b we=%b", mem_addr, mem_din, mem_wtbt, mem_rd, mem_we),
                $sformatf("addr=%h din=%h wtbt=%b we=%b", req_addr[25*w +: 25], req_wdata[16*w +: 16],
                          req_wtbt[2*w +: 2], req_we[w]));
        end
      end
    end
    prev_grant = grant; prev_req = req; prev_ready = mem_ready; prev_rstn = reset_n;
  end

  task automatic cont_port(input int p, input int count);
    int n;
    for (int i = 0; i < count; i++)
      do_req(p, i[0], (p << 8) + 16 + 2 * i, 16'($urandom), 2'b11, 1'b0, n);
  endtask

  task automatic rand_port(input int p);
    int n;
    logic [1:0] be;
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 4)) @(posedge clk);
      be = 2'($urandom_range(1, 3));
      do_req(p, 1'($urandom_range(0, 1)), (p << 8) + 2 * $urandom_range(0, 7), 16'($urandom), be, 1'b0, n);
    end
  endtask

  initial begin
    int n, got;
    int exp_order[6];
`ifdef SDRAM_ARB_PORT0_PRIO_EN
    exp_order = '{0, 0, 0, 1, 2, 1};
`else
    exp_order = '{0, 1, 2, 0, 1, 2};
`endif
    ctl_mem[32'h100] = 16'hBEEF;
    ref_mem[32'h100] = 16'hBEEF;
    repeat (3) @(posedge clk); #1;
    check("reset_state", grant == 0 && ack == 0 && rdata == 0 && mem_din == 0 && mem_wtbt == 0 && !mem_rd && !mem_we,
          $sformatf("grant=%b ack=%b rdata=%h din=%h wtbt=%b rd=%b we=%b", grant, ack, rdata, mem_din, mem_wtbt, mem_rd, mem_we),
          "all zero");
    reset_n = 1'b1;

    // Startup gating: ready held low, pending read must not be granted.
    fork
      do_req(1, 1'b0, 'h100, 16'h0, 2'b11, 1'b0, n);
      begin
        repeat (5000) @(posedge clk); #1;
        check("startup_gate", grant_events == 0 && grant == 0, $sformatf("grants=%0d", grant_events), "grants=0");
        startup_hold = 0;
      end
    join

    do_req(1, 1'b0, 'h100, 16'h0, 2'b11, 1'b0, n);
    check("read_latency", n == 8, $sformatf("%0d", n), "8");
    do_req(0, 1'b1, 'h200, 16'h1234, 2'b11, 1'b0, n);
    do_req(2, 1'b0, 'h200, 16'h0, 2'b11, 1'b0, n);

    hit_mode = 1;
    do_req(2, 1'b0, 'h200, 16'h0, 2'b11, 1'b0, n);
    check("hit_latency", n == 3, $sformatf("%0d", n), "3");
    hit_mode = 0;

    stuck_mode = 1;
    do_req(2, 1'b0, 'h300, 16'h0, 2'b11, 1'b1, n);
    check("timeout_latency", n == TO + 2, $sformatf("%0d", n), $sformatf("%0d", TO + 2));
    stuck_mode = 0;
    do_req(0, 1'b0, 'h300, 16'h0, 2'b11, 1'b0, n);

    // Reset in the middle of WAIT: transfer abandoned without ack.
    stuck_mode = 1;
    @(posedge clk); #1;
    req_we[1] = 1'b0; req_addr[25 +: 25] = 25'h140; req[1] = 1'b1;
    n = 0;
    while (!grant[1] && n < 50) begin @(posedge clk); #1; n++; end
    check("reset_test_grant", grant[1] == 1'b1, $sformatf("grant=%b", grant), "grant=010");
    repeat (5) @(posedge clk); #1;
    reset_n = 1'b0; #1;
    check("reset_mid_wait", !mem_rd && grant == 0 && ack == 0,
          $sformatf("rd=%b grant=%b ack=%b", mem_rd, grant, ack), "rd=0 grant=0 ack=0");
    req[1] = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1; stuck_mode = 0;
    do_req(1, 1'b0, 'h140, 16'h0, 2'b11, 1'b0, n);

    // Contention from a fresh round-robin pointer.
    repeat (20) @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1; lat = 3;
    grant_log.delete();
    fork
      cont_port(0, 3);
      cont_port(1, 3);
      cont_port(2, 3);
    join
    for (int i = 0; i < 6; i++) begin
      got = (i < grant_log.size()) ? grant_log[i] : -1;
      check($sformatf("contention_order[%0d]", i), got == exp_order[i], $sformatf("%0d", got), $sformatf("%0d", exp_order[i]));
    end

    rand_mode = 1;
    fork
      rand_port(0);
      rand_port(1);
      rand_port(2);
    join
    rand_mode = 0;

    repeat (10) @(posedge clk); #1;
    check("scoreboard_empty", exp_q.size() == 0, $sformatf("%0d left", exp_q.size()), "0 left");
    check("rise_count", rise_count == grant_events, $sformatf("%0d rises", rise_count), $sformatf("%0d", grant_events));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: got simulation still running, expected finish");
    $display("%0d/%0d checks passed", passes, checks + 1);
    $fatal(1, "global timeout");
  end
endmodule
